// File: rtl/gestor_alarma_bateria.sv
// Battery alarm manager: debounces the monitor's severity level and drives a
// four-state alarm FSM with a blinking LED, silenceable buzzer and shutdown request.
module gestor_alarma_bateria #(
  parameter int ESTABLE_CICLOS   = 4,
  parameter int PERIODO_PARPADEO = 8,
  parameter int TIEMPO_APAGADO   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advertencia_bateria_1,
  input  logic       advertencia_bateria_2,
  input  logic       optimo,
  input  logic       aceptable,
  input  logic       regular,
  input  logic       critico,
  input  logic       reconocer,
  output logic [1:0] nivel_filtrado,
  output logic [1:0] estado,
  output logic       led_alarma,
  output logic       zumbador,
  output logic       solicitud_apagado
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    AVISO   = 2'd1,
    CRITICO = 2'd2,
    APAGADO = 2'd3
  } estado_t;

  localparam int CW = $clog2(ESTABLE_CICLOS + 1);
  localparam int TW = $clog2(TIEMPO_APAGADO);
  localparam int BW = (PERIODO_PARPADEO > 1) ? $clog2(PERIODO_PARPADEO) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(ESTABLE_CICLOS);
  localparam logic [TW-1:0] TMR_MAX   = TW'(TIEMPO_APAGADO - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(PERIODO_PARPADEO - 1);

  logic [1:0]    nivel_codificado, nivel_crudo;
  logic [1:0]    candidato_q, candidato_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    nivel_q, nivel_d;
  estado_t       estado_q, estado_d, objetivo;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          silencio_q, silencio_d;
  logic          led_q, led_d;
  logic          zumbador_q, zumbador_d;
  logic          solicitud_q, solicitud_d;

  // A missing status bit is treated as critical; any battery warning forces at least "regular".
  always_comb begin
    nivel_codificado = 2'd3;
    if (critico)        nivel_codificado = 2'd3;
    else if (regular)   nivel_codificado = 2'd2;
    else if (aceptable) nivel_codificado = 2'd1;
    else if (optimo)    nivel_codificado = 2'd0;
    nivel_crudo = nivel_codificado;
    if ((advertencia_bateria_1 || advertencia_bateria_2) && (nivel_codificado < 2'd2))
      nivel_crudo = 2'd2;
  end

  always_comb begin
    candidato_d = candidato_q;
    cnt_d       = cnt_q;
    nivel_d     = nivel_q;
    if (nivel_crudo != candidato_q) begin
      candidato_d = nivel_crudo;
      cnt_d       = CW'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CNT_MAX) nivel_d = candidato_q;
    end
  end

  always_comb begin
    case (nivel_q)
      2'd0, 2'd1: objetivo = NORMAL;
      2'd2:       objetivo = AVISO;
      default:    objetivo = CRITICO;
    endcase

    if (estado_q == APAGADO)
      estado_d = APAGADO;
    else if ((estado_q == CRITICO) && (tmr_q == TMR_MAX))
      estado_d = APAGADO;
    else
      estado_d = objetivo;

    tmr_d = ((estado_q == CRITICO) && (estado_d == CRITICO)) ? tmr_q + TW'(1) : '0;

    // A state change always clears the silence, even if reconocer is sampled on the same edge.
    silencio_d = silencio_q;
    if (estado_d != estado_q)
      silencio_d = 1'b0;
    else if (reconocer && ((estado_q == AVISO) || (estado_q == CRITICO)))
      silencio_d = 1'b1;

    led_d   = 1'b1;
    blink_d = '0;
    case (estado_d)
      NORMAL: led_d = 1'b0;
      AVISO: begin
        if (estado_q != AVISO) begin
          led_d   = 1'b1;
          blink_d = '0;
        end else if (blink_q == BLINK_MAX) begin
          led_d   = ~led_q;
          blink_d = '0;
        end else begin
          led_d   = led_q;
          blink_d = blink_q + BW'(1);
        end
      end
      default: led_d = 1'b1;
    endcase

    zumbador_d  = ((estado_d == AVISO) || (estado_d == CRITICO)) && !silencio_d;
    solicitud_d = (estado_d == APAGADO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidato_q <= 2'd0;
      cnt_q       <= '0;
      nivel_q     <= 2'd0;
      estado_q    <= NORMAL;
      tmr_q       <= '0;
      blink_q     <= '0;
      silencio_q  <= 1'b0;
      led_q       <= 1'b0;
      zumbador_q  <= 1'b0;
      solicitud_q <= 1'b0;
    end else begin
      candidato_q <= candidato_d;
      cnt_q       <= cnt_d;
      nivel_q     <= nivel_d;
      estado_q    <= estado_d;
      tmr_q       <= tmr_d;
      blink_q     <= blink_d;
      silencio_q  <= silencio_d;
      led_q       <= led_d;
      zumbador_q  <= zumbador_d;
      solicitud_q <= solicitud_d;
    end
  end

  assign nivel_filtrado    = nivel_q;
  assign estado            = estado_q;
  assign led_alarma        = led_q;
  assign zumbador          = zumbador_q;
  assign solicitud_apagado = solicitud_q;

endmodule

// File: tb/tb_gestor_alarma_bateria.sv
// Self-checking bench for gestor_alarma_bateria: directed scenarios followed by
// randomized status streams, all compared against a behavioural model.
module tb_gestor_alarma_bateria;

  localparam int E = 4;
  localparam int P = 8;
  localparam int T = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       advertencia_bateria_1 = 1'b0;
  logic       advertencia_bateria_2 = 1'b0;
  logic       optimo = 1'b0;
  logic       aceptable = 1'b0;
  logic       regular = 1'b0;
  logic       critico = 1'b0;
  logic       reconocer = 1'b0;
  logic [1:0] nivel_filtrado;
  logic [1:0] estado;
  logic       led_alarma;
  logic       zumbador;
  logic       solicitud_apagado;

  int checks = 0;
  int errors = 0;

  gestor_alarma_bateria #(
    .ESTABLE_CICLOS(E),
    .PERIODO_PARPADEO(P),
    .TIEMPO_APAGADO(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .advertencia_bateria_1(advertencia_bateria_1),
    .advertencia_bateria_2(advertencia_bateria_2),
    .optimo(optimo),
    .aceptable(aceptable),
    .regular(regular),
    .critico(critico),
    .reconocer(reconocer),
    .nivel_filtrado(nivel_filtrado),
    .estado(estado),
    .led_alarma(led_alarma),
    .zumbador(zumbador),
    .solicitud_apagado(solicitud_apagado)
  );

  always #5 clk = ~clk;

  // Behavioural model: history of raw levels since reset plus entry timestamps of each state.
  int         cyc;
  int         hist[$];
  logic [1:0] m_nivel;
  logic [1:0] m_estado;
  logic       m_sil, m_led, m_zum, m_sol;
  int         crit_entry, aviso_entry;

  function automatic int rawLevel();
    int lvl;
    if (critico)        lvl = 3;
    else if (regular)   lvl = 2;
    else if (aceptable) lvl = 1;
    else if (optimo)    lvl = 0;
    else                lvl = 3;
    if ((advertencia_bateria_1 || advertencia_bateria_2) && lvl < 2) lvl = 2;
    return lvl;
  endfunction

  task automatic modelReset();
    hist.delete();
    m_nivel = 2'd0; m_estado = 2'd0;
    m_sil = 1'b0; m_led = 1'b0; m_zum = 1'b0; m_sol = 1'b0;
    crit_entry = 0; aviso_entry = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic modelEdge();
    logic [1:0] nuevo_nivel, nuevo_estado;
    bit todos_iguales;
    cyc++;
    hist.push_back(rawLevel());
    if (hist.size() > E) void'(hist.pop_front());
    nuevo_nivel = m_nivel;
    if (hist.size() == E) begin
      todos_iguales = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) todos_iguales = 1'b0;
      if (todos_iguales) nuevo_nivel = 2'(hist[0]);
    end
    if (m_estado == 2'd3)                                nuevo_estado = 2'd3;
    else if (m_estado == 2'd2 && cyc - crit_entry >= T) nuevo_estado = 2'd3;
    else if (m_nivel == 2'd3)                            nuevo_estado = 2'd2;
    else if (m_nivel == 2'd2)                            nuevo_estado = 2'd1;
    else                                                 nuevo_estado = 2'd0;
    if (nuevo_estado != m_estado) begin
      m_sil = 1'b0;
      if (nuevo_estado == 2'd2) crit_entry = cyc;
      if (nuevo_estado == 2'd1) aviso_entry = cyc;
    end else if (reconocer && (m_estado == 2'd1 || m_estado == 2'd2)) begin
      m_sil = 1'b1;
    end
    if (nuevo_estado == 2'd0)      m_led = 1'b0;
    else if (nuevo_estado == 2'd1) m_led = (((cyc - aviso_entry) / P) % 2) == 0;
    else                           m_led = 1'b1;
    m_zum    = (nuevo_estado == 2'd1 || nuevo_estado == 2'd2) && !m_sil;
    m_sol    = (nuevo_estado == 2'd3);
    m_nivel  = nuevo_nivel;
    m_estado = nuevo_estado;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    chk("nivel_filtrado", nivel_filtrado, m_nivel);
    chk("estado", estado, m_estado);
    chk("led_alarma", {1'b0, led_alarma}, {1'b0, m_led});
    chk("zumbador", {1'b0, zumbador}, {1'b0, m_zum});
    chk("solicitud_apagado", {1'b0, solicitud_apagado}, {1'b0, m_sol});
  endtask

  // One rising edge: update the model at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  // Status vector order is {critico, regular, aceptable, optimo}.
  task automatic applyStimulus(input logic [3:0] st, input logic a1, input logic a2,
                               input logic rec, input int n);
    {critico, regular, aceptable, optimo} = st;
    advertencia_bateria_1 = a1;
    advertencia_bateria_2 = a2;
    reconocer = rec;
    repeat (n) step();
  endtask

  // Asynchronous reset: outputs must clear immediately, before any clock edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    chk("reset_nivel", nivel_filtrado, 2'd0);
    chk("reset_estado", estado, 2'd0);
    chk("reset_led", {1'b0, led_alarma}, 2'd0);
    chk("reset_zumbador", {1'b0, zumbador}, 2'd0);
    chk("reset_solicitud", {1'b0, solicitud_apagado}, 2'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold critico and time the CRITICO -> APAGADO transition from the outputs.
  task automatic measureApagado(input string tag);
    int inicio, fin;
    inicio = -1;
    fin = -1;
    {critico, regular, aceptable, optimo} = 4'b1000;
    reconocer = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (estado == 2'd2 && inicio < 0) inicio = i;
      if (estado == 2'd3) begin
        fin = i;
        break;
      end
    end
    chk({tag, "_apagado_alcanzado"}, {1'b0, (fin >= 0 && inicio >= 0)}, 2'd1);
    checks++;
    assert (fin - inicio == T) else begin
      errors++;
      $error("[TB] FAIL %s_latencia observed=%0d expected=%0d", tag, fin - inicio, T);
    end
  endtask

  // Directed scenarios first, then randomized status streams with occasional resets.
  initial begin
    logic [3:0] st;
    cyc = 0;
    modelReset();
    #2;
    doReset();

    applyStimulus(4'b0001, 0, 0, 0, 20);
    applyStimulus(4'b0100, 0, 0, 0, 30);
    applyStimulus(4'b0100, 0, 0, 1, 1);
    applyStimulus(4'b0100, 0, 0, 0, 20);
    applyStimulus(4'b0001, 0, 0, 0, 10);

    applyStimulus(4'b1000, 0, 0, 0, 3);
    applyStimulus(4'b0001, 0, 0, 0, 10);
    applyStimulus(4'b1000, 0, 0, 0, 4);
    applyStimulus(4'b0001, 0, 0, 0, 10);

    doReset();
    measureApagado("critico_sostenido");
    applyStimulus(4'b0001, 0, 0, 0, 10);
    doReset();

    applyStimulus(4'b0010, 0, 1, 0, 10);
    applyStimulus(4'b0000, 0, 0, 0, 10);
    applyStimulus(4'b0000, 0, 0, 1, 1);
    applyStimulus(4'b0000, 0, 0, 0, 5);
    applyStimulus(4'b0100, 0, 0, 0, 10);
    measureApagado("reentrada_critico");
    doReset();

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) < 8) st = 4'b0001 << $urandom_range(0, 3);
      else                          st = 4'($urandom_range(0, 15));
      applyStimulus(st, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0), $urandom_range(1, 8));
      if (m_estado == 2'd3 && $urandom_range(0, 2) == 0) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
